// File: rtl/landrover_seq_ctrl.sv
// landrover_seq_ctrl
//   Arbitrates three requesters (driver, cruise, safety) and serialises the
//   winner's X pattern, LSB first, toward the landrover FSM. Every burst is
//   followed by a guard interval of HOLD_CYC idle cycles. A safety request
//   preempts a driver/cruise burst and cuts a driver/cruise guard interval
//   short.
//
// Ports
//   clk            clock, all state on rising edge
//   reset          asynchronous active-low reset
//   req[2:0]       requests: bit0 driver, bit1 cruise, bit2 safety
//   len0/1/2       burst length in bits (0-7) per requester
//   pat0/1/2       X pattern per requester, LSB issued first
//   x, x_en        X value and its valid-step strobe (x is 0 when x_en is 0)
//   gnt[2:0]       one-cycle one-hot acceptance pulse
//   abort[2:0]     one-cycle one-hot pulse to a preempted requester
//   owner[1:0]     current burst owner, 3 = none
//   busy           high while in SEND or HOLD
//
// State | meaning
// IDLE  | no burst; any request sampled here is arbitrated
// SEND  | issuing bits of the owner's pattern
// HOLD  | guard interval after a burst, x_en held low

module landrover_seq_ctrl #(
  parameter int HOLD_CYC = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] req,
  input  logic [2:0] len0,
  input  logic [2:0] len1,
  input  logic [2:0] len2,
  input  logic [6:0] pat0,
  input  logic [6:0] pat1,
  input  logic [6:0] pat2,
  output logic       x,
  output logic       x_en,
  output logic [2:0] gnt,
  output logic [2:0] abort,
  output logic [1:0] owner,
  output logic       busy
);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_HOLD} state_t;

  localparam logic [1:0] OWN_NONE = 2'd3;
  localparam logic [1:0] OWN_SAFE = 2'd2;

  state_t     r_state, w_state;
  logic [1:0] r_owner, w_owner;
  logic       r_pref,  w_pref;    // 1 = cruise preferred in the next tie
  logic [2:0] r_left,  w_left;    // bits still to issue after the current one
  logic [6:0] r_shift, w_shift;
  logic [3:0] r_hold,  w_hold;    // HOLD cycles remaining after the current one
  logic       r_x,     w_x;
  logic       r_x_en,  w_x_en;
  logic [2:0] r_gnt,   w_gnt;
  logic [2:0] r_abort, w_abort;
  logic       r_busy,  w_busy;

  logic       w_do_grant;
  logic       w_enter_hold;
  logic [1:0] w_win;
  logic [2:0] w_len;
  logic [6:0] w_pat;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_owner <= OWN_NONE;
      r_pref  <= 1'b0;
      r_left  <= '0;
      r_shift <= '0;
      r_hold  <= '0;
      r_x     <= 1'b0;
      r_x_en  <= 1'b0;
      r_gnt   <= '0;
      r_abort <= '0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_owner <= w_owner;
      r_pref  <= w_pref;
      r_left  <= w_left;
      r_shift <= w_shift;
      r_hold  <= w_hold;
      r_x     <= w_x;
      r_x_en  <= w_x_en;
      r_gnt   <= w_gnt;
      r_abort <= w_abort;
      r_busy  <= w_busy;
    end
  end

  always_comb begin
    w_state      = r_state;
    w_owner      = r_owner;
    w_pref       = r_pref;
    w_left       = r_left;
    w_shift      = r_shift;
    w_hold       = r_hold;
    w_x          = 1'b0;
    w_x_en       = 1'b0;
    w_gnt        = '0;
    w_abort      = '0;
    w_busy       = 1'b0;
    w_do_grant   = 1'b0;
    w_enter_hold = 1'b0;
    w_win        = 2'd0;
    w_len        = '0;
    w_pat        = '0;

    case (r_state)
      S_IDLE: begin
        if (|req) begin
          w_do_grant = 1'b1;
          if (req[2])                w_win = OWN_SAFE;
          else if (req[0] && req[1]) w_win = r_pref ? 2'd1 : 2'd0;
          else                       w_win = req[0] ? 2'd0 : 2'd1;
        end
      end
      S_SEND: begin
        if (r_left != 3'd0) begin
          if (req[2] && (r_owner != OWN_SAFE)) begin
            w_abort    = 3'b001 << r_owner;
            w_do_grant = 1'b1;
            w_win      = OWN_SAFE;
          end else begin
            w_x     = r_shift[0];
            w_x_en  = 1'b1;
            w_shift = r_shift >> 1;
            w_left  = r_left - 3'd1;
          end
        end else begin
          // last bit went out on the previous edge; a safety request
          // arriving now is served from the guard interval instead
          w_enter_hold = 1'b1;
        end
      end
      S_HOLD: begin
        if (req[2] && (r_owner != OWN_SAFE)) begin
          w_do_grant = 1'b1;
          w_win      = OWN_SAFE;
        end else if (r_hold == 4'd0) begin
          w_state = S_IDLE;
          w_owner = OWN_NONE;
        end else begin
          w_hold = r_hold - 4'd1;
        end
      end
      default: begin
        w_state = S_IDLE;
        w_owner = OWN_NONE;
      end
    endcase

    if (w_do_grant) begin
      case (w_win)
        2'd0:    begin w_len = len0; w_pat = pat0; end
        2'd1:    begin w_len = len1; w_pat = pat1; end
        default: begin w_len = len2; w_pat = pat2; end
      endcase
      w_gnt   = 3'b001 << w_win;
      w_owner = w_win;
      if (w_win != OWN_SAFE) w_pref = (w_win == 2'd0);
      if (w_len != 3'd0) begin
        w_state = S_SEND;
        w_x     = w_pat[0];
        w_x_en  = 1'b1;
        w_shift = w_pat >> 1;
        w_left  = w_len - 3'd1;
      end else begin
        w_enter_hold = 1'b1;
      end
    end

    if (w_enter_hold) begin
      if (HOLD_CYC > 0) begin
        w_state = S_HOLD;
        w_hold  = 4'(HOLD_CYC - 1);
      end else begin
        w_state = S_IDLE;
        w_owner = OWN_NONE;
      end
    end

    w_busy = (w_state != S_IDLE);
  end

  assign x     = r_x;
  assign x_en  = r_x_en;
  assign gnt   = r_gnt;
  assign abort = r_abort;
  assign owner = r_owner;
  assign busy  = r_busy;

endmodule

// File: tb/tb_landrover_seq_ctrl.sv
// Self-checking bench for landrover_seq_ctrl: directed scenarios followed by
// randomized requester traffic, checked cycle by cycle against a burst-level
// reference model (pending bits kept as a queue, guard interval as a count).

module tb_landrover_seq_ctrl;

  localparam int HOLD_CYC = 4;

  logic       clk;
  logic       reset;
  logic [2:0] req;
  logic [2:0] len0, len1, len2;
  logic [6:0] pat0, pat1, pat2;
  logic       x, x_en;
  logic [2:0] gnt, abort;
  logic [1:0] owner;
  logic       busy;

  logic [2:0] tb_req;
  logic [2:0] tb_len [3];
  logic [6:0] tb_pat [3];

  assign req  = tb_req;
  assign len0 = tb_len[0];
  assign len1 = tb_len[1];
  assign len2 = tb_len[2];
  assign pat0 = tb_pat[0];
  assign pat1 = tb_pat[1];
  assign pat2 = tb_pat[2];

  landrover_seq_ctrl #(.HOLD_CYC(HOLD_CYC)) dut (
    .clk   (clk),
    .reset (reset),
    .req   (req),
    .len0  (len0),
    .len1  (len1),
    .len2  (len2),
    .pat0  (pat0),
    .pat1  (pat1),
    .pat2  (pat2),
    .x     (x),
    .x_en  (x_en),
    .gnt   (gnt),
    .abort (abort),
    .owner (owner),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, obs, exp, $time);
    end
  endtask

  // reference model: 0 idle, 1 sending, 2 guard interval
  int m_mode;
  int m_owner;
  int m_pref;     // 0 driver wins a tie, 1 cruise wins a tie
  int m_hold;     // guard cycles still to spend
  bit m_bits[$];  // pattern bits not yet issued
  int e_x, e_xen, e_gnt, e_abort, e_owner, e_busy;

  task automatic model_reset();
    m_mode = 0; m_owner = 3; m_pref = 0; m_hold = 0;
    m_bits.delete();
    e_x = 0; e_xen = 0; e_gnt = 0; e_abort = 0; e_owner = 3; e_busy = 0;
  endtask

  task automatic model_enter_hold();
    if (HOLD_CYC > 0) begin
      m_mode = 2;
      m_hold = HOLD_CYC;
    end else begin
      m_mode  = 0;
      m_owner = 3;
    end
  endtask

  task automatic model_grant(input int w);
    e_gnt   = 1 << w;
    m_owner = w;
    if (w == 0) m_pref = 1;
    if (w == 1) m_pref = 0;
    m_bits.delete();
    for (int i = 0; i < int'(tb_len[w]); i++) m_bits.push_back(tb_pat[w][i]);
    if (m_bits.size() > 0) begin
      e_x    = m_bits.pop_front();
      e_xen  = 1;
      m_mode = 1;
    end else begin
      model_enter_hold();
    end
  endtask

  task automatic model_step(input logic [2:0] r);
    int w;
    e_x = 0; e_xen = 0; e_gnt = 0; e_abort = 0;
    case (m_mode)
      0: if (r != 3'b000) begin
        if (r[2])              w = 2;
        else if (r[0] && r[1]) w = m_pref;
        else                   w = r[0] ? 0 : 1;
        model_grant(w);
      end
      1: if (m_bits.size() > 0) begin
        if (r[2] && m_owner != 2) begin
          e_abort = 1 << m_owner;
          model_grant(2);
        end else begin
          e_x   = m_bits.pop_front();
          e_xen = 1;
        end
      end else begin
        model_enter_hold();
      end
      default: begin
        if (r[2] && m_owner != 2) begin
          model_grant(2);
        end else begin
          m_hold--;
          if (m_hold == 0) begin
            m_mode  = 0;
            m_owner = 3;
          end
        end
      end
    endcase
    e_owner = m_owner;
    e_busy  = (m_mode != 0);
  endtask

  int cyc = 0;
  int n_xen, n_busy, n_drv, xbits;
  int g_val[$];
  int g_cyc[$];
  bit keep_req = 0;
  bit rnd_mode = 0;

  task automatic clear_stats();
    n_xen = 0; n_busy = 0; n_drv = 0; xbits = 0;
    g_val.delete(); g_cyc.delete();
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      model_step(tb_req);
      #1;
      chk("x",     int'(x),     e_x);
      chk("x_en",  int'(x_en),  e_xen);
      chk("gnt",   int'(gnt),   e_gnt);
      chk("abort", int'(abort), e_abort);
      chk("owner", int'(owner), e_owner);
      chk("busy",  int'(busy),  e_busy);
      if (x_en) begin
        xbits = xbits | (int'(x) << n_xen);
        n_xen++;
        if (owner == 2'd0) n_drv++;
      end
      if (busy) n_busy++;
      if (gnt != 3'b000) begin
        g_val.push_back(int'(gnt));
        g_cyc.push_back(cyc);
      end
      cyc++;
      for (int r = 0; r < 3; r++) begin
        if (e_gnt[r] && !keep_req) begin
          if (!rnd_mode || $urandom_range(0, 99) >= 15) tb_req[r] = 1'b0;
        end
        if (rnd_mode && !tb_req[r] && $urandom_range(0, 99) < 25) begin
          tb_len[r] = 3'($urandom_range(0, 7));
          tb_pat[r] = 7'($urandom);
          tb_req[r] = 1'b1;
        end
      end
    end
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_x"},     int'(x),     0);
    chk({tag, "_x_en"},  int'(x_en),  0);
    chk({tag, "_gnt"},   int'(gnt),   0);
    chk({tag, "_abort"}, int'(abort), 0);
    chk({tag, "_owner"}, int'(owner), 3);
    chk({tag, "_busy"},  int'(busy),  0);
  endtask

  initial begin
    reset  = 1'b0;
    tb_req = '0;
    for (int r = 0; r < 3; r++) begin
      tb_len[r] = '0;
      tb_pat[r] = '0;
    end
    model_reset();
    #12;
    chk_reset_outs("rst");
    @(negedge clk);
    reset = 1'b1;

    // two-way contention with driver preferred out of reset
    clear_stats();
    tb_len[0] = 3'd1; tb_pat[0] = 7'h01;
    tb_len[1] = 3'd1; tb_pat[1] = 7'h00;
    tb_req    = 3'b011;
    keep_req  = 1;
    run_cycles(7);
    tb_req   = 3'b000;
    keep_req = 0;
    chk("s2_ngnt", g_val.size(), 2);
    if (g_val.size() >= 2) begin
      chk("s2_first",  g_val[0], 1);
      chk("s2_second", g_val[1], 2);
      chk("s2_gap",    g_cyc[1] - g_cyc[0], HOLD_CYC + 2);
    end
    run_cycles(8);

    // simple driver burst
    clear_stats();
    tb_len[0] = 3'd3; tb_pat[0] = 7'b0000101;
    tb_req    = 3'b001;
    run_cycles(10);
    chk("s1_nxen",  n_xen,  3);
    chk("s1_bits",  xbits,  5);
    chk("s1_nbusy", n_busy, 3 + HOLD_CYC);

    // safety preempts a long driver burst after two bits
    clear_stats();
    tb_len[0] = 3'd7; tb_pat[0] = 7'b1010110;
    tb_req    = 3'b001;
    run_cycles(2);
    tb_len[2] = 3'd3; tb_pat[2] = 7'b0000011;
    tb_req[2] = 1'b1;
    run_cycles(1);
    chk("s3_abort", int'(abort), 1);
    chk("s3_gnt",   int'(gnt),   4);
    chk("s3_x",     int'(x),     1);
    run_cycles(12);
    chk("s3_drv_bits", n_drv, 2);

    // zero-length cruise request
    clear_stats();
    tb_len[1] = 3'd0; tb_pat[1] = 7'h7f;
    tb_req    = 3'b010;
    run_cycles(8);
    chk("s4_nxen",  n_xen,  0);
    chk("s4_nbusy", n_busy, HOLD_CYC);
    chk("s4_gnt",   g_val.size() > 0 ? g_val[0] : 0, 2);

    // safety during the guard interval after a cruise burst
    clear_stats();
    tb_len[1] = 3'd2; tb_pat[1] = 7'b0000010;
    tb_req    = 3'b010;
    run_cycles(3);
    tb_len[2] = 3'd1; tb_pat[2] = 7'b0000001;
    tb_req[2] = 1'b1;
    run_cycles(1);
    chk("s6_gnt", int'(gnt), 4);
    run_cycles(8);

    // asynchronous reset in the middle of a burst
    tb_len[0] = 3'd5; tb_pat[0] = 7'b0011111;
    tb_req    = 3'b001;
    run_cycles(2);
    #2;
    reset = 1'b0;
    #1;
    chk_reset_outs("s5");
    model_reset();
    tb_req = 3'b000;
    @(negedge clk);
    reset = 1'b1;
    clear_stats();
    tb_len[0] = 3'd2; tb_pat[0] = 7'b0000001;
    tb_req    = 3'b001;
    run_cycles(8);
    chk("s5_ngnt", g_val.size(), 1);
    chk("s5_nxen", n_xen, 2);

    // randomized traffic
    rnd_mode = 1;
    run_cycles(600);
    rnd_mode = 0;
    tb_req   = 3'b000;
    run_cycles(15);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
